// File: rtl/mem_access_stage.sv
// ----------------------------------------------------------------------------
// mem_access_stage
//
// MEM stage of the 5-stage pipeline. It sits directly downstream of the EX/MEM
// register and does four things:
//   - issues data-memory read/write requests over a variable-latency req/ack bus
//   - stalls the upstream stages while a request is outstanding
//   - selects the write-back value
//   - holds the MEM/WB pipeline register, which feeds WB and forwarding
//
// Parameters
//   TIMEOUT_CYCLES  WAIT cycles allowed before a bus error is declared
//                   (1 .. 2**CNT_W-1)
//   CNT_W           width of the timeout counter
//
// Ports
//   clk, reset      rising-edge clock; asynchronous active-low reset
//   IALUResult      EX/MEM ALU result, also the memory byte address
//   IMemWrData      EX/MEM store data
//   IPCAdd4         EX/MEM link value (PC+4)
//   IResult         EX/MEM auxiliary result (LUI/MUL, ...)
//   IWriteReg       EX/MEM destination register
//   ICRegWrite      EX/MEM register-write enable
//   ICMemtoReg      write-back select: 00 ALU, 01 memory, 10 PC+4, 11 aux
//   ICMemRead       EX/MEM load
//   ICMemWrite      EX/MEM store
//   dmem_rdata      memory read data, valid while dmem_ack is 1
//   dmem_ack        memory completion, 1-cycle pulse
//   dmem_req        registered request, held high until ack or timeout
//   dmem_we         registered write enable, valid while dmem_req is 1
//   dmem_addr       registered word address {IALUResult[31:2], 2'b00}
//   dmem_wdata      registered store data
//   OStall          freeze PC, IF/ID, ID/EX and EX/MEM
//   OWBData         MEM/WB write-back value
//   OWriteReg       MEM/WB destination register
//   OCRegWrite      MEM/WB register-write enable
//   OMisalign       1-cycle pulse: load/store with a non-word-aligned address
//   OBusErr         1-cycle pulse: the request timed out
//   dbg_state       current FSM state (IDLE=0, WAIT=1, DONE=2)
//
// Bus handshake: dmem_req rises on the edge that leaves IDLE. It stays high,
// with addr/we/wdata stable, until the first cycle in which dmem_ack is 1.
// The request also ends after TIMEOUT_CYCLES WAIT cycles without an ack.
// An ack is honoured only in WAIT. An ack that arrives in IDLE or DONE, or
// after a timeout, is ignored.
// ----------------------------------------------------------------------------
module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IALUResult,
  input  logic [31:0] IMemWrData,
  input  logic [31:0] IPCAdd4,
  input  logic [31:0] IResult,
  input  logic [4:0]  IWriteReg,
  input  logic        ICRegWrite,
  input  logic [1:0]  ICMemtoReg,
  input  logic        ICMemRead,
  input  logic        ICMemWrite,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic        OStall,
  output logic [31:0] OWBData,
  output logic [4:0]  OWriteReg,
  output logic        OCRegWrite,
  output logic        OMisalign,
  output logic        OBusErr,
  output logic [1:0]  dbg_state
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             err;
  logic [31:0]      rdata_q;

  logic             mem_op;
  logic             misaligned;
  logic             start;
  logic             timeout_hit;
  logic [31:0]      wb_sel;

  assign mem_op      = ICMemRead | ICMemWrite;
  assign misaligned  = |IALUResult[1:0];
  assign start       = (state == IDLE) && mem_op && !misaligned;
  assign timeout_hit = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign dbg_state   = state;

  // The stall is gated with reset. Without the gate, a held load on the
  // inputs would keep OStall high while the block sits in reset in IDLE.
  assign OStall = reset & (start | (state == WAIT));

  // Memory data comes from the captured read register. It is only meaningful
  // when the value is consumed in DONE.
  always_comb begin
    wb_sel = IALUResult;
    case (ICMemtoReg)
      2'b00:   wb_sel = IALUResult;
      2'b01:   wb_sel = rdata_q;
      2'b10:   wb_sel = IPCAdd4;
      default: wb_sel = IResult;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      err        <= 1'b0;
      rdata_q    <= '0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      OWBData    <= '0;
      OWriteReg  <= '0;
      OCRegWrite <= 1'b0;
      OMisalign  <= 1'b0;
      OBusErr    <= 1'b0;
    end else begin
      // Both pulses last exactly one cycle unless they are re-armed below.
      OMisalign <= 1'b0;
      OBusErr   <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_op) begin
            // Both a misaligned access and a started access put a bubble
            // into MEM/WB. A started access completes its write-back in DONE.
            OCRegWrite <= 1'b0;
            if (misaligned) begin
              OMisalign <= 1'b1;
            end else begin
              dmem_req   <= 1'b1;
              // When both read and write are set, the access is a read.
              dmem_we    <= ICMemWrite & ~ICMemRead;
              dmem_addr  <= {IALUResult[31:2], 2'b00};
              dmem_wdata <= IMemWrData;
              cnt        <= '0;
              state      <= WAIT;
            end
          end else begin
            OWBData    <= wb_sel;
            OWriteReg  <= IWriteReg;
            OCRegWrite <= ICRegWrite;
          end
        end
        WAIT: begin
          OCRegWrite <= 1'b0;
          if (dmem_ack) begin
            rdata_q  <= dmem_rdata;
            dmem_req <= 1'b0;
            state    <= DONE;
          end else if (timeout_hit) begin
            dmem_req <= 1'b0;
            OBusErr  <= 1'b1;
            err      <= 1'b1;
            state    <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          // Upstream is released in this cycle. The EX/MEM inputs are still
          // the ones for this access, so the select can use them directly.
          OWBData    <= wb_sel;
          OWriteReg  <= IWriteReg;
          OCRegWrite <= ICRegWrite & ~err;
          err        <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

  localparam int TO = 4;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] IALUResult = '0, IMemWrData = '0, IPCAdd4 = '0, IResult = '0;
  logic [4:0]  IWriteReg = '0;
  logic        ICRegWrite = 1'b0;
  logic [1:0]  ICMemtoReg = '0;
  logic        ICMemRead = 1'b0, ICMemWrite = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        dmem_ack = 1'b0;
  logic        dmem_req, dmem_we, OStall, OCRegWrite, OMisalign, OBusErr;
  logic [31:0] dmem_addr, dmem_wdata, OWBData;
  logic [4:0]  OWriteReg;
  logic [1:0]  dbg_state;

  mem_access_stage #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .IALUResult(IALUResult), .IMemWrData(IMemWrData), .IPCAdd4(IPCAdd4),
    .IResult(IResult), .IWriteReg(IWriteReg), .ICRegWrite(ICRegWrite),
    .ICMemtoReg(ICMemtoReg), .ICMemRead(ICMemRead), .ICMemWrite(ICMemWrite),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .OStall(OStall), .OWBData(OWBData),
    .OWriteReg(OWriteReg), .OCRegWrite(OCRegWrite), .OMisalign(OMisalign),
    .OBusErr(OBusErr), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  int buserr_cycles = 0;
  int exp_buserr = 0;
  logic tb_valid = 1'b0;

  // {chk_data, misalign, regwrite, wreg[4:0], data[31:0]}
  logic [39:0] exp_q[$];
  // {we, addr[31:0], wdata[31:0], len[7:0]}
  logic [72:0] bus_q[$];
  // {ack_lat[7:0] (0 = never ack), rdata[31:0]}
  logic [39:0] resp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [31:0] alu, input logic [31:0] wd, input logic [31:0] pc4,
                       input logic [31:0] res, input logic [4:0] wreg, input logic rw,
                       input logic [1:0] m2r, input logic rd, input logic wr);
    IALUResult = alu; IMemWrData = wd; IPCAdd4 = pc4; IResult = res;
    IWriteReg = wreg; ICRegWrite = rw; ICMemtoReg = m2r; ICMemRead = rd; ICMemWrite = wr;
  endtask

  task automatic drive_nop();
    drive(32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0);
  endtask

  task automatic expect_wb(input logic [31:0] data, input logic [4:0] wreg, input logic rw,
                           input logic mis, input logic chk);
    exp_q.push_back({chk, mis, rw, wreg, data});
  endtask

  task automatic expect_bus(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [7:0] len, input logic [7:0] lat, input logic [31:0] rdata);
    bus_q.push_back({we, addr, wd, len});
    resp_q.push_back({lat, rdata});
  endtask

  // Presents the current inputs as a valid instruction. Returns once the
  // stage accepts it (a cycle with OStall low), and checks how many cycles
  // that took.
  task automatic wait_accept(input string name, input int exp_cyc);
    int  cyc;
    logic acc;
    cyc = 0;
    acc = 1'b0;
    tb_valid = 1'b1;
    while (!acc && cyc < 50) begin
      @(negedge clk);
      acc = (OStall === 1'b0);
      @(posedge clk); #1;
      cyc++;
    end
    if (!acc) begin
      checks++; errors++;
      $display("FAIL %s accept: timed out after %0d cycles", name, cyc);
    end else begin
      check({name, " cycles"}, 64'(cyc), 64'(exp_cyc));
    end
    tb_valid = 1'b0;
    drive_nop();
  endtask

  // ---------------- write-back monitor ----------------
  initial begin
    logic        ret;
    logic [39:0] e;
    forever begin
      @(negedge clk);
      ret = tb_valid && (OStall === 1'b0) && reset;
      @(posedge clk); #1;
      if (ret) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL wb_unexpected: retire with empty queue");
        end else begin
          e = exp_q.pop_front();
          check("wb_regwrite", 64'(OCRegWrite), 64'(e[37]));
          check("wb_misalign", 64'(OMisalign), 64'(e[38]));
          if (e[39]) begin
            check("wb_data", 64'(OWBData), 64'(e[31:0]));
            check("wb_wreg", 64'(OWriteReg), 64'(e[36:32]));
          end
        end
      end
    end
  end

  // ---------------- bus monitor ----------------
  initial begin
    logic        active;
    int          cnt;
    logic [72:0] b;
    active = 1'b0;
    cnt = 0;
    b = '0;
    forever begin
      @(posedge clk); #1;
      if (OBusErr === 1'b1) buserr_cycles++;
      if (!reset) begin
        active = 1'b0;
      end else if (dmem_req && !active) begin
        active = 1'b1;
        cnt = 1;
        if (bus_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL bus_unexpected: request with empty queue");
          b = '0;
        end else begin
          b = bus_q.pop_front();
          check("bus_we", 64'(dmem_we), 64'(b[72]));
          check("bus_addr", 64'(dmem_addr), 64'(b[71:40]));
          check("bus_wdata", 64'(dmem_wdata), 64'(b[39:8]));
        end
      end else if (dmem_req) begin
        cnt++;
      end else if (active) begin
        active = 1'b0;
        check("bus_req_len", 64'(cnt), 64'(b[7:0]));
      end
    end
  end

  // ---------------- memory responder ----------------
  initial begin
    logic        prev;
    logic [39:0] r;
    prev = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (reset && dmem_req && !prev && resp_q.size() != 0) begin
        r = resp_q.pop_front();
        if (r[39:32] != 8'd0) begin
          repeat (int'(r[39:32]) - 1) begin @(posedge clk); #1; end
          dmem_ack = 1'b1;
          dmem_rdata = r[31:0];
          @(posedge clk); #1;
          dmem_ack = 1'b0;
          dmem_rdata = 32'h0;
        end
      end
      prev = dmem_req;
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", 64'(dmem_req), 64'd0);
    check("rst_stall", 64'(OStall), 64'd0);
    check("rst_wbdata", 64'(OWBData), 64'd0);
    check("rst_regwrite", 64'(OCRegWrite), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    // ALU op, 1-cycle latency
    drive(32'h10, 32'h0, 32'h0, 32'h0, 5'd5, 1'b1, 2'b00, 1'b0, 1'b0);
    expect_wb(32'h10, 5'd5, 1'b1, 1'b0, 1'b1);
    wait_accept("alu", 1);

    // Load, ack in the second WAIT cycle: 3 stall cycles
    drive(32'h100, 32'h0, 32'h0, 32'h0, 5'd7, 1'b1, 2'b01, 1'b1, 1'b0);
    expect_bus(1'b0, 32'h100, 32'h0, 8'd2, 8'd2, 32'hDEADBEEF);
    expect_wb(32'hDEADBEEF, 5'd7, 1'b1, 1'b0, 1'b1);
    wait_accept("load", 4);

    // Store, ack in the first WAIT cycle: 2 stall cycles, no register write
    drive(32'h204, 32'h1234, 32'h0, 32'h0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b1);
    expect_bus(1'b1, 32'h204, 32'h1234, 8'd1, 8'd1, 32'h0);
    expect_wb(32'h204, 5'd0, 1'b0, 1'b0, 1'b1);
    wait_accept("store", 3);

    // Misaligned load: no request, bubble, misalign pulse
    drive(32'h102, 32'h0, 32'h0, 32'h0, 5'd9, 1'b1, 2'b01, 1'b1, 1'b0);
    expect_wb(32'h0, 5'd0, 1'b0, 1'b1, 1'b0);
    wait_accept("misalign_ld", 1);

    // Link-value and aux-result selects
    drive(32'h8, 32'h0, 32'h44, 32'h0, 5'd31, 1'b1, 2'b10, 1'b0, 1'b0);
    expect_wb(32'h44, 5'd31, 1'b1, 1'b0, 1'b1);
    wait_accept("sel_pc4", 1);
    drive(32'h8, 32'h0, 32'h44, 32'hCAFE, 5'd2, 1'b1, 2'b11, 1'b0, 1'b0);
    expect_wb(32'hCAFE, 5'd2, 1'b1, 1'b0, 1'b1);
    wait_accept("sel_aux", 1);

    // Timeout: request held TO cycles, bus error, no register write
    drive(32'h300, 32'h0, 32'h0, 32'h0, 5'd3, 1'b1, 2'b01, 1'b1, 1'b0);
    expect_bus(1'b0, 32'h300, 32'h0, 8'(TO), 8'd0, 32'h0);
    expect_wb(32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    exp_buserr++;
    wait_accept("timeout", TO + 2);

    // The error flag must be cleared for the next load
    drive(32'h8, 32'h0, 32'h0, 32'h0, 5'd4, 1'b1, 2'b01, 1'b1, 1'b0);
    expect_bus(1'b0, 32'h8, 32'h0, 8'd1, 8'd1, 32'h77);
    expect_wb(32'h77, 5'd4, 1'b1, 1'b0, 1'b1);
    wait_accept("load_after_err", 3);

    // Read and write both set: treated as a read, ack in the third WAIT cycle
    drive(32'h40, 32'hFFFF, 32'h0, 32'h0, 5'd12, 1'b1, 2'b01, 1'b1, 1'b1);
    expect_bus(1'b0, 32'h40, 32'hFFFF, 8'd3, 8'd3, 32'h55AA);
    expect_wb(32'h55AA, 5'd12, 1'b1, 1'b0, 1'b1);
    wait_accept("rd_wr_both", 5);

    // Misaligned store
    drive(32'h207, 32'h9, 32'h0, 32'h0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b1);
    expect_wb(32'h0, 5'd0, 1'b0, 1'b1, 1'b0);
    wait_accept("misalign_st", 1);

    // Reset asserted in the middle of WAIT
    drive(32'h400, 32'h0, 32'h0, 32'h0, 5'd6, 1'b1, 2'b01, 1'b1, 1'b0);
    expect_bus(1'b0, 32'h400, 32'h0, 8'd0, 8'd0, 32'h0);
    @(posedge clk); #1;
    check("mid_wait_req", 64'(dmem_req), 64'd1);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    check("async_req", 64'(dmem_req), 64'd0);
    check("async_stall", 64'(OStall), 64'd0);
    check("async_addr", 64'(dmem_addr), 64'd0);
    check("async_wbdata", 64'(OWBData), 64'd0);
    check("async_wreg", 64'(OWriteReg), 64'd0);
    check("async_regwrite", 64'(OCRegWrite), 64'd0);
    check("async_state", 64'(dbg_state), 64'd0);
    @(posedge clk); #1;
    drive_nop();
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    check("post_rst_state", 64'(dbg_state), 64'd0);
    check("post_rst_req", 64'(dmem_req), 64'd0);

    drive(32'h99, 32'h0, 32'h0, 32'h0, 5'd1, 1'b1, 2'b00, 1'b0, 1'b0);
    expect_wb(32'h99, 5'd1, 1'b1, 1'b0, 1'b1);
    wait_accept("alu_after_rst", 1);

    repeat (5) @(posedge clk);
    #2;
    check("wb_queue_empty", 64'(exp_q.size()), 64'd0);
    check("bus_queue_empty", 64'(bus_q.size()), 64'd0);
    check("buserr_pulses", 64'(buserr_cycles), 64'(exp_buserr));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
